// File: rtl/t05_spi_byte_engine.sv
`timescale 1ns/1ps
// t05_spi_byte_engine
// SPI mode-0 master byte engine. Shifts one byte out on mosi while shifting
// one byte in from miso, MSB first. Runs entirely on clk; spi_tick from the
// clock divider is edge-detected and used only as a pacing strobe.
//
// Ports:
//   clk        system clock, all registers on its rising edge
//   reset      asynchronous, active-high reset
//   spi_tick   divider output; each 0->1 transition is one SPI half-period
//   start      request a byte transfer (honoured only in IDLE)
//   tx_byte    byte to send, latched on an accepted start
//   cs_hold    keep cs_n low after this byte (sampled on the trailing tick)
//   cs_release in IDLE, drive cs_n high
//   miso       serial data from the slave
//   sclk       SPI clock, idles low
//   mosi       serial data to the slave, idles high
//   cs_n       active-low chip select
//   busy       transfer in progress
//   done       one-cycle pulse when rx_byte is valid
//   rx_byte    last received byte, held until the next done
module t05_spi_byte_engine (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_tick,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       cs_hold,
  input  logic       cs_release,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic       cs_n,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_byte
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_HIGH,
    S_LOW,
    S_TRAIL
  } state_t;

  state_t     state;
  logic       spi_tick_q;
  logic       tick;
  logic [2:0] bit_cnt;
  logic [7:0] tx_sr;
  logic [7:0] rx_sr;

  // A level held high yields a single tick.
  assign tick = spi_tick & ~spi_tick_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      spi_tick_q <= 1'b0;
      sclk       <= 1'b0;
      mosi       <= 1'b1;
      cs_n       <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      rx_byte    <= '0;
      bit_cnt    <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
    end else begin
      spi_tick_q <= spi_tick;
      done       <= 1'b0;
      case (state)
        S_IDLE: begin
          // A tick coinciding with start is deliberately not consumed, so
          // LEAD always provides at least one half-period of CS setup.
          if (start) begin
            tx_sr   <= tx_byte;
            bit_cnt <= 3'd7;
            cs_n    <= 1'b0;
            busy    <= 1'b1;
            mosi    <= tx_byte[7];
            state   <= S_LEAD;
          end else if (cs_release) begin
            cs_n <= 1'b1;
          end
        end
        S_LEAD: begin
          if (tick) begin
            sclk  <= 1'b1;
            rx_sr <= {rx_sr[6:0], miso};
            state <= S_HIGH;
          end
        end
        S_HIGH: begin
          if (tick) begin
            sclk <= 1'b0;
            if (bit_cnt == 3'd0) begin
              state <= S_TRAIL;
            end else begin
              bit_cnt <= bit_cnt - 3'd1;
              tx_sr   <= {tx_sr[6:0], 1'b0};
              mosi    <= tx_sr[6];
              state   <= S_LOW;
            end
          end
        end
        S_LOW: begin
          if (tick) begin
            sclk  <= 1'b1;
            rx_sr <= {rx_sr[6:0], miso};
            state <= S_HIGH;
          end
        end
        S_TRAIL: begin
          if (tick) begin
            rx_byte <= rx_sr;
            done    <= 1'b1;
            busy    <= 1'b0;
            mosi    <= 1'b1;
            cs_n    <= ~cs_hold;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_t05_spi_byte_engine.sv
`timescale 1ns/1ps
// Directed testbench for t05_spi_byte_engine.
module tb_t05_spi_byte_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       spi_tick;
  logic       start;
  logic [7:0] tx_byte;
  logic       cs_hold;
  logic       cs_release;
  logic       miso;
  logic       miso_drv;
  logic       loopback;
  logic       sclk;
  logic       mosi;
  logic       cs_n;
  logic       busy;
  logic       done;
  logic [7:0] rx_byte;

  int n_checks = 0;
  int n_fail   = 0;

  // monitor state
  logic       sclk_prev = 1'b0;
  logic       mosi_prev = 1'b1;
  logic [7:0] mon_bits  = '0;
  int         mon_rises = 0;
  int         done_cnt  = 0;
  int         cs_hi_cnt = 0;
  int         mosi_viol = 0;

  int snap_done;
  int snap_rises;
  int snap_cs;

  assign miso = loopback ? mosi : miso_drv;

  always #5 clk = ~clk;

  t05_spi_byte_engine dut (
    .clk        (clk),
    .reset      (reset),
    .spi_tick   (spi_tick),
    .start      (start),
    .tx_byte    (tx_byte),
    .cs_hold    (cs_hold),
    .cs_release (cs_release),
    .miso       (miso),
    .sclk       (sclk),
    .mosi       (mosi),
    .cs_n       (cs_n),
    .busy       (busy),
    .done       (done),
    .rx_byte    (rx_byte)
  );

  // Captures mosi at each sclk rise, counts done pulses, cs_n-high cycles and
  // any mosi change while sclk stays high.
  always @(negedge clk) begin
    if (sclk && !sclk_prev) begin
      mon_bits  <= {mon_bits[6:0], mosi};
      mon_rises <= mon_rises + 1;
    end
    if (sclk && sclk_prev && (mosi !== mosi_prev))
      mosi_viol <= mosi_viol + 1;
    if (done === 1'b1)
      done_cnt <= done_cnt + 1;
    if (cs_n === 1'b1)
      cs_hi_cnt <= cs_hi_cnt + 1;
    sclk_prev <= sclk;
    mosi_prev <= mosi;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got no summary, expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic accept(input logic [7:0] b);
    start   = 1'b1;
    tx_byte = b;
    @(negedge clk);
    start = 1'b0;
    check_eq("accept busy", {31'd0, busy}, 32'd1);
    check_eq("accept cs_n", {31'd0, cs_n}, 32'd0);
    check_eq("accept mosi", {31'd0, mosi}, {31'd0, b[7]});
    check_eq("accept sclk", {31'd0, sclk}, 32'd0);
  endtask

  // Ticks numbered first..last after acceptance, 3 idle cycles before each.
  task automatic run_ticks(input int unsigned first, input int unsigned last);
    for (int unsigned k = first; k <= last; k++) begin
      repeat (3) @(negedge clk);
      spi_tick = 1'b1;
      @(negedge clk);
      spi_tick = 1'b0;
      check_eq($sformatf("tick%0d sclk", k), {31'd0, sclk}, (k <= 16) ? (k % 2) : 32'd0);
      check_eq($sformatf("tick%0d done", k), {31'd0, done}, (k == 17) ? 32'd1 : 32'd0);
      check_eq($sformatf("tick%0d busy", k), {31'd0, busy}, (k == 17) ? 32'd0 : 32'd1);
    end
  endtask

  initial begin
    reset      = 1'b1;
    spi_tick   = 1'b0;
    start      = 1'b0;
    tx_byte    = '0;
    cs_hold    = 1'b0;
    cs_release = 1'b0;
    miso_drv   = 1'b0;
    loopback   = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst sclk", {31'd0, sclk}, 32'd0);
    check_eq("rst mosi", {31'd0, mosi}, 32'd1);
    check_eq("rst cs_n", {31'd0, cs_n}, 32'd1);
    check_eq("rst busy", {31'd0, busy}, 32'd0);
    check_eq("rst done", {31'd0, done}, 32'd0);
    check_eq("rst rx_byte", {24'd0, rx_byte}, 32'h00);
    reset = 1'b0;
    @(negedge clk);

    // 1: loopback 0xA5
    snap_done = done_cnt;
    accept(8'hA5);
    run_ticks(1, 17);
    check_eq("t1 cs_n", {31'd0, cs_n}, 32'd1);
    #1;
    check_eq("t1 mosi seq", {24'd0, mon_bits}, 32'hA5);
    check_eq("t1 rx_byte", {24'd0, rx_byte}, 32'hA5);
    check_eq("t1 done count", done_cnt - snap_done, 32'd1);

    // 2: miso high, send 0x00
    loopback = 1'b0;
    miso_drv = 1'b1;
    snap_done = done_cnt;
    accept(8'h00);
    run_ticks(1, 17);
    check_eq("t2 idle mosi", {31'd0, mosi}, 32'd1);
    #1;
    check_eq("t2 mosi seq", {24'd0, mon_bits}, 32'h00);
    check_eq("t2 rx_byte", {24'd0, rx_byte}, 32'hFF);
    check_eq("t2 done count", done_cnt - snap_done, 32'd1);

    // 3: start mid-transfer is ignored
    loopback = 1'b1;
    snap_done = done_cnt;
    accept(8'h3C);
    run_ticks(1, 4);
    @(negedge clk);
    start   = 1'b1;
    tx_byte = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    check_eq("t3 busy after 2nd start", {31'd0, busy}, 32'd1);
    run_ticks(5, 17);
    #1;
    check_eq("t3 mosi seq", {24'd0, mon_bits}, 32'h3C);
    check_eq("t3 rx_byte", {24'd0, rx_byte}, 32'h3C);
    check_eq("t3 done count", done_cnt - snap_done, 32'd1);

    // 4: back-to-back with cs_hold, start in the done cycle
    cs_hold   = 1'b1;
    snap_done = done_cnt;
    accept(8'h12);
    snap_cs = cs_hi_cnt;
    run_ticks(1, 17);
    check_eq("t4 cs_n at done", {31'd0, cs_n}, 32'd0);
    check_eq("t4 rx_byte 1", {24'd0, rx_byte}, 32'h12);
    accept(8'h34);
    run_ticks(1, 17);
    #1;
    check_eq("t4 cs_n high cycles", cs_hi_cnt - snap_cs, 32'd0);
    check_eq("t4 mosi seq 2", {24'd0, mon_bits}, 32'h34);
    check_eq("t4 rx_byte 2", {24'd0, rx_byte}, 32'h34);
    check_eq("t4 done count", done_cnt - snap_done, 32'd2);
    cs_hold = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("t4 cs_n held idle", {31'd0, cs_n}, 32'd0);
    cs_release = 1'b1;
    @(negedge clk);
    cs_release = 1'b0;
    check_eq("t4 cs_n released", {31'd0, cs_n}, 32'd1);

    // 5: asynchronous reset after the 5th tick
    accept(8'h5A);
    run_ticks(1, 5);
    #2;
    reset = 1'b1;
    #1;
    check_eq("t5 rst cs_n", {31'd0, cs_n}, 32'd1);
    check_eq("t5 rst sclk", {31'd0, sclk}, 32'd0);
    check_eq("t5 rst busy", {31'd0, busy}, 32'd0);
    check_eq("t5 rst rx_byte", {24'd0, rx_byte}, 32'h00);
    check_eq("t5 rst mosi", {31'd0, mosi}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    snap_done = done_cnt;
    accept(8'hC3);
    run_ticks(1, 17);
    #1;
    check_eq("t5 rx_byte", {24'd0, rx_byte}, 32'hC3);
    check_eq("t5 done count", done_cnt - snap_done, 32'd1);

    // 6: start coincident with a tick edge, then spi_tick held high
    snap_done = done_cnt;
    @(negedge clk);
    start    = 1'b1;
    tx_byte  = 8'h96;
    spi_tick = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    spi_tick = 1'b0;
    check_eq("t6 busy", {31'd0, busy}, 32'd1);
    repeat (3) @(negedge clk);
    check_eq("t6 lead waits", {31'd0, sclk}, 32'd0);
    run_ticks(1, 1);
    repeat (3) @(negedge clk);
    snap_rises = mon_rises;
    spi_tick = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    check_eq("t6 held sclk", {31'd0, sclk}, 32'd0);
    check_eq("t6 held rises", mon_rises - snap_rises, 32'd0);
    spi_tick = 1'b0;
    @(negedge clk);
    check_eq("t6 fall no tick", {31'd0, sclk}, 32'd0);
    run_ticks(3, 17);
    #1;
    check_eq("t6 rx_byte", {24'd0, rx_byte}, 32'h96);
    check_eq("t6 mosi seq", {24'd0, mon_bits}, 32'h96);
    check_eq("t6 done count", done_cnt - snap_done, 32'd1);

    check_eq("mosi stable while sclk high", mosi_viol, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
